// File: rtl/ghost_pkg.sv
// Shared types, constants and helpers for the ghost movement scheduler.
package ghost_pkg;

  localparam int GRID_W = 32;

  typedef logic [$clog2(GRID_W)-1:0] coord_t;
  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    F_UP   = 3'd1,
    F_MID  = 3'd2,
    F_DN   = 3'd3,
    F_WAIT = 3'd4,
    MOVE   = 3'd5,
    DONE   = 3'd6
  } sched_state_t;

  // Positions are encoded y*32+x.
  localparam pos_t HOME   [4] = '{10'd367, 10'd463, 10'd461, 10'd465};
  localparam pos_t CORNER [4] = '{10'd31, 10'd0, 10'd1023, 10'd992};

  // Coordinates wrap mod 32 in both axes; the horizontal wrap is the tunnel.
  function automatic pos_t stepPos(pos_t p, dir_t d);
    coord_t x;
    coord_t y;
    x = p[4:0];
    y = p[9:5];
    case (d)
      UP:      y = y - 5'd1;
      LEFT:    x = x - 5'd1;
      DOWN:    y = y + 5'd1;
      default: x = x + 5'd1;
    endcase
    return {y, x};
  endfunction

  function automatic logic [10:0] cellDist(pos_t a, pos_t t);
    logic [9:0] ax;
    logic [9:0] ay;
    ax = (a[4:0] >= t[4:0]) ? {5'd0, a[4:0] - t[4:0]} : {5'd0, t[4:0] - a[4:0]};
    ay = (a[9:5] >= t[9:5]) ? {5'd0, a[9:5] - t[9:5]} : {5'd0, t[9:5] - a[9:5]};
    return {1'b0, ax * ax} + {1'b0, ay * ay};
  endfunction

endpackage

// File: rtl/ghost_step_select.sv
// Combinational move chooser: picks the open neighbour nearest the target.
module ghost_step_select
  import ghost_pkg::*;
(
  input  pos_t        curPos,
  input  dir_t        curDir,
  input  pos_t        target,
  input  logic [31:0] rowUp,
  input  logic [31:0] rowMid,
  input  logic [31:0] rowDn,
  input  logic        reverseOk,
  output pos_t        nextPos,
  output dir_t        nextDir
);

  coord_t      x;
  coord_t      xl;
  coord_t      xr;
  dir_t        revDir;
  logic [3:0]  openDir;
  logic        found;
  logic [10:0] bestDist;
  logic [10:0] candDist;
  pos_t        cand;

  always_comb begin
    x        = curPos[4:0];
    xl       = x - 5'd1;
    xr       = x + 5'd1;
    revDir   = dir_t'(curDir ^ 2'd2);
    openDir  = {~rowMid[xr], ~rowDn[x], ~rowMid[xl], ~rowUp[x]};
    found    = 1'b0;
    bestDist = '1;
    candDist = '0;
    cand     = curPos;
    nextPos  = curPos;
    nextDir  = curDir;
    // Strict less-than keeps the earlier direction on ties: UP, LEFT, DOWN, RIGHT.
    for (int i = 0; i < 4; i++) begin
      cand     = stepPos(curPos, dir_t'(i[1:0]));
      candDist = cellDist(cand, target);
      if (openDir[i] && ((i[1:0] != revDir) || reverseOk) &&
          (!found || (candDist < bestDist))) begin
        found    = 1'b1;
        bestDist = candDist;
        nextPos  = cand;
        nextDir  = dir_t'(i[1:0]);
      end
    end
    if (!found && openDir[revDir]) begin
      nextPos = stepPos(curPos, revDir);
      nextDir = revDir;
    end
  end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Walks all four ghosts through one shared wall-fetch and move datapath per tick.
// Optional scatter/chase mode timer is enabled with GHOST_SCATTER_EN.
module ghost_move_scheduler
  import ghost_pkg::*;
#(
  parameter int SCATTER_ROUNDS = 7,
  parameter int CHASE_ROUNDS   = 20
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_tick,
  input  logic [3:0][9:0]  target_i,
  input  logic [3:0]       dead_i,
  output logic [4:0]       wall_addr,
  output logic             wall_rd_en,
  input  logic [31:0]      wall_data,
  output logic [3:0][9:0]  ghost_pos,
  output logic [3:0][1:0]  ghost_dir,
  output logic             mode,
  output logic             busy,
  output logic             round_done,
  output logic             overrun,
  output sched_state_t     dbgState
);

  sched_state_t     state;
  sched_state_t     stateNext;
  logic [1:0]       g;
  logic [31:0]      rowUpQ;
  logic [31:0]      rowMidQ;
  logic [31:0]      rowDnQ;
  logic [3:0][9:0]  posQ;
  logic [3:0][1:0]  dirQ;
  logic             modeQ;
  logic             reversePending;
  pos_t             curPos;
  coord_t           curY;
  pos_t             tgt;
  pos_t             selPos;
  dir_t             selDir;

  assign curPos    = posQ[g];
  assign curY      = curPos[9:5];
  assign ghost_pos = posQ;
  assign ghost_dir = dirQ;
  assign mode      = modeQ;
  assign dbgState  = state;

`ifdef GHOST_SCATTER_EN
  assign tgt = modeQ ? target_i[g] : CORNER[g];
`else
  assign tgt = target_i[g];
`endif

  ghost_step_select u_select (
    .curPos    (curPos),
    .curDir    (dir_t'(dirQ[g])),
    .target    (tgt),
    .rowUp     (rowUpQ),
    .rowMid    (rowMidQ),
    .rowDn     (rowDnQ),
    .reverseOk (reversePending),
    .nextPos   (selPos),
    .nextDir   (selDir)
  );

  // Handshake: start_tick is accepted only while busy is low; a tick seen
  // while busy is dropped and latches overrun until reset.
  always_comb begin
    stateNext  = state;
    wall_rd_en = 1'b0;
    wall_addr  = '0;
    busy       = (state != IDLE);
    round_done = 1'b0;
    case (state)
      IDLE:   if (start_tick) stateNext = F_UP;
      F_UP: begin
        stateNext  = F_MID;
        wall_rd_en = 1'b1;
        wall_addr  = curY - 5'd1;
      end
      F_MID: begin
        stateNext  = F_DN;
        wall_rd_en = 1'b1;
        wall_addr  = curY;
      end
      F_DN: begin
        stateNext  = F_WAIT;
        wall_rd_en = 1'b1;
        wall_addr  = curY + 5'd1;
      end
      F_WAIT: stateNext = MOVE;
      MOVE:   stateNext = (g == 2'd3) ? DONE : F_UP;
      DONE: begin
        round_done = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // RAM data lags the address by one cycle, so each row lands one state later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      g       <= 2'd0;
      rowUpQ  <= '0;
      rowMidQ <= '0;
      rowDnQ  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        posQ[i] <= HOME[i];
        dirQ[i] <= UP;
      end
    end else begin
      state <= stateNext;
      if (start_tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE:   g <= 2'd0;
        F_MID:  rowUpQ <= wall_data;
        F_DN:   rowMidQ <= wall_data;
        F_WAIT: rowDnQ <= wall_data;
        MOVE: begin
          if (dead_i[g]) begin
            posQ[g] <= HOME[g];
            dirQ[g] <= UP;
          end else begin
            posQ[g] <= selPos;
            dirQ[g] <= selDir;
          end
          g <= g + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef GHOST_SCATTER_EN
  localparam int CNT_W = 8;
  logic [CNT_W-1:0] roundCnt;
  logic [CNT_W-1:0] roundLimit;

  assign roundLimit = modeQ ? CNT_W'(CHASE_ROUNDS - 1) : CNT_W'(SCATTER_ROUNDS - 1);

  // A mode flip arms one round in which every ghost may turn around.
  always_ff @(posedge clk) begin
    if (reset) begin
      modeQ          <= 1'b0;
      roundCnt       <= '0;
      reversePending <= 1'b0;
    end else if (state == DONE) begin
      reversePending <= 1'b0;
      if (roundCnt == roundLimit) begin
        modeQ          <= ~modeQ;
        roundCnt       <= '0;
        reversePending <= 1'b1;
      end else begin
        roundCnt <= roundCnt + CNT_W'(1);
      end
    end
  end
`else
  assign modeQ          = 1'b1;
  assign reversePending = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench for ghost_move_scheduler plus unit vectors for ghost_step_select.
module tb_ghost_move_scheduler;
  import ghost_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_tick;
  logic [3:0][9:0] target_i;
  logic [3:0]      dead_i;
  logic [4:0]      wall_addr;
  logic            wall_rd_en;
  logic [31:0]     wall_data;
  logic [3:0][9:0] ghost_pos;
  logic [3:0][1:0] ghost_dir;
  logic            mode;
  logic            busy;
  logic            round_done;
  logic            overrun;
  sched_state_t    dbgState;

  pos_t        selCurPos;
  dir_t        selCurDir;
  pos_t        selTarget;
  logic [31:0] selRowUp;
  logic [31:0] selRowMid;
  logic [31:0] selRowDn;
  logic        selRevOk;
  pos_t        selNextPos;
  dir_t        selNextDir;

  logic [31:0] maze [32];
  int          testsRun = 0;
  int          testsFailed = 0;

  int          busyCnt;
  int          doneAt;
  logic [4:0]  addrAt1;
  logic        rdAt1;
  logic [9:0]  pos0At5;
  logic [9:0]  pos0At6;

  always #5 clk = ~clk;

  always @(posedge clk) if (wall_rd_en) wall_data <= maze[wall_addr];

  ghost_move_scheduler #(.SCATTER_ROUNDS(2), .CHASE_ROUNDS(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_tick (start_tick),
    .target_i   (target_i),
    .dead_i     (dead_i),
    .wall_addr  (wall_addr),
    .wall_rd_en (wall_rd_en),
    .wall_data  (wall_data),
    .ghost_pos  (ghost_pos),
    .ghost_dir  (ghost_dir),
    .mode       (mode),
    .busy       (busy),
    .round_done (round_done),
    .overrun    (overrun),
    .dbgState   (dbgState)
  );

  ghost_step_select u_sel (
    .curPos    (selCurPos),
    .curDir    (selCurDir),
    .target    (selTarget),
    .rowUp     (selRowUp),
    .rowMid    (selRowMid),
    .rowDn     (selRowDn),
    .reverseOk (selRevOk),
    .nextPos   (selNextPos),
    .nextDir   (selNextDir)
  );

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_tick = 1'b0;
    dead_i = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Pulses start_tick and follows the round; k counts cycles after T.
  task automatic run_round();
    int k;
    busyCnt = 0;
    doneAt = -1;
    start_tick = 1'b1;
    tick();
    start_tick = 1'b0;
    k = 1;
    while (k <= 40) begin
      if (k == 1) begin
        addrAt1 = wall_addr;
        rdAt1 = wall_rd_en;
      end
      if (k == 5) pos0At5 = ghost_pos[0];
      if (k == 6) pos0At6 = ghost_pos[0];
      if (busy) busyCnt++;
      if (round_done) doneAt = k;
      if (!busy) break;
      tick();
      k++;
    end
    testsRun++;
    if (k > 40) begin
      testsFailed++;
      $display("FAIL round_timeout: busy still %0b after %0d cycles, required idle", busy, k - 1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic expMode;
`ifdef GHOST_SCATTER_EN
    expMode = 1'b0;
`else
    expMode = 1'b1;
`endif
    testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy: got %b want 0", busy); end
    testsRun++; if (round_done !== 1'b0) begin testsFailed++; $display("FAIL reset_round_done: got %b want 0", round_done); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    testsRun++; if (wall_rd_en !== 1'b0 || wall_addr !== 5'd0) begin testsFailed++; $display("FAIL reset_wall: got rd=%b addr=%0d want 0/0", wall_rd_en, wall_addr); end
    testsRun++; if (dbgState !== IDLE) begin testsFailed++; $display("FAIL reset_state: got %0d want %0d", dbgState, IDLE); end
    testsRun++; if (mode !== expMode) begin testsFailed++; $display("FAIL reset_mode: got %b want %b", mode, expMode); end
    testsRun++;
    if (ghost_pos[0] !== 10'd367 || ghost_pos[1] !== 10'd463 || ghost_pos[2] !== 10'd461 || ghost_pos[3] !== 10'd465) begin
      testsFailed++;
      $display("FAIL reset_pos: got %0d %0d %0d %0d want 367 463 461 465", ghost_pos[0], ghost_pos[1], ghost_pos[2], ghost_pos[3]);
    end
    testsRun++; if (ghost_dir !== 8'h00) begin testsFailed++; $display("FAIL reset_dir: got %h want 00", ghost_dir); end
  endtask

  task automatic test_first_move();
    do_reset();
    target_i = '0;
    target_i[0] = 10'(10 * 32 + 20);
    run_round();
    testsRun++; if (rdAt1 !== 1'b1 || addrAt1 !== 5'd10) begin testsFailed++; $display("FAIL first_fetch: got rd=%b addr=%0d want 1/10", rdAt1, addrAt1); end
    testsRun++; if (pos0At5 !== 10'd367) begin testsFailed++; $display("FAIL first_pos_T5: got %0d want 367", pos0At5); end
    testsRun++; if (pos0At6 !== 10'd368) begin testsFailed++; $display("FAIL first_pos_T6: got %0d want 368", pos0At6); end
    testsRun++; if (ghost_dir[0] !== 2'd3) begin testsFailed++; $display("FAIL first_dir: got %0d want 3", ghost_dir[0]); end
    testsRun++; if (busyCnt != 21) begin testsFailed++; $display("FAIL first_busy_cycles: got %0d want 21", busyCnt); end
    testsRun++; if (doneAt != 21) begin testsFailed++; $display("FAIL first_round_done_at: got %0d want 21", doneAt); end
  endtask

  task automatic test_back_to_back();
    run_round();
    testsRun++; if (rdAt1 !== 1'b1) begin testsFailed++; $display("FAIL b2b_accept: got rd=%b want 1", rdAt1); end
    testsRun++; if (busyCnt != 21 || doneAt != 21) begin testsFailed++; $display("FAIL b2b_timing: got busy=%0d done=%0d want 21/21", busyCnt, doneAt); end
    testsRun++; if (pos0At6 !== 10'd369) begin testsFailed++; $display("FAIL b2b_pos: got %0d want 369", pos0At6); end
  endtask

  task automatic test_overrun();
    do_reset();
    start_tick = 1'b1;
    tick();
    start_tick = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    start_tick = 1'b1;
    tick();
    start_tick = 1'b0;
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("FAIL overrun_set: got %b want 1", overrun); end
    testsRun++; if (dbgState !== F_UP) begin testsFailed++; $display("FAIL overrun_ignored: got state %0d want %0d", dbgState, F_UP); end
    tick();
    tick();
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    testsRun++; if (dbgState !== IDLE || busy !== 1'b0) begin testsFailed++; $display("FAIL midround_reset: got state=%0d busy=%b want 0/0", dbgState, busy); end
    testsRun++; if (ghost_pos[0] !== 10'd367) begin testsFailed++; $display("FAIL midround_reset_pos: got %0d want 367", ghost_pos[0]); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("FAIL midround_reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_y0_wrap();
    do_reset();
    target_i = '0;
    target_i[0] = 10'd15;
    for (int r = 0; r < 11; r++) run_round();
    testsRun++; if (ghost_pos[0] !== 10'd15 || ghost_dir[0] !== 2'd0) begin testsFailed++; $display("FAIL climb_to_row0: got pos=%0d dir=%0d want 15/0", ghost_pos[0], ghost_dir[0]); end
    run_round();
    testsRun++; if (addrAt1 !== 5'd31) begin testsFailed++; $display("FAIL row0_up_addr: got %0d want 31", addrAt1); end
    testsRun++; if (ghost_pos[0] !== 10'd14 || ghost_dir[0] !== 2'd1) begin testsFailed++; $display("FAIL tie_left_over_right: got pos=%0d dir=%0d want 14/1", ghost_pos[0], ghost_dir[0]); end
    run_round();
    testsRun++; if (ghost_pos[0] !== 10'd46 || ghost_dir[0] !== 2'd2) begin testsFailed++; $display("FAIL no_reverse_down: got pos=%0d dir=%0d want 46/2", ghost_pos[0], ghost_dir[0]); end
  endtask

  task automatic test_dead();
    dead_i = 4'b0100;
    run_round();
    dead_i = '0;
    testsRun++; if (ghost_pos[2] !== 10'd461 || ghost_dir[2] !== 2'd0) begin testsFailed++; $display("FAIL dead_home: got pos=%0d dir=%0d want 461/0", ghost_pos[2], ghost_dir[2]); end
  endtask

  task automatic test_scatter();
    do_reset();
    target_i = '0;
    target_i[0] = 10'd352;
    run_round();
    testsRun++; if (mode !== 1'b0) begin testsFailed++; $display("FAIL scatter_round1_mode: got %b want 0", mode); end
    run_round();
    testsRun++; if (mode !== 1'b1) begin testsFailed++; $display("FAIL scatter_flip_mode: got %b want 1", mode); end
    testsRun++; if (ghost_pos[0] !== 10'd369) begin testsFailed++; $display("FAIL scatter_corner_pos: got %0d want 369", ghost_pos[0]); end
    run_round();
    testsRun++; if (ghost_pos[0] !== 10'd368 || ghost_dir[0] !== 2'd1) begin testsFailed++; $display("FAIL flip_reverse: got pos=%0d dir=%0d want 368/1", ghost_pos[0], ghost_dir[0]); end
    target_i[0] = 10'd383;
    run_round();
    testsRun++; if (ghost_pos[0] !== 10'd336 || ghost_dir[0] !== 2'd0) begin testsFailed++; $display("FAIL reverse_one_round_only: got pos=%0d dir=%0d want 336/0", ghost_pos[0], ghost_dir[0]); end
  endtask

  task automatic test_step_select();
    pos_t        vPos [9];
    logic [1:0]  vDir [9];
    pos_t        vTgt [9];
    logic [31:0] vUp  [9];
    logic [31:0] vMid [9];
    logic [31:0] vDn  [9];
    logic        vRev [9];
    pos_t        ePos [9];
    logic [1:0]  eDir [9];
    // wrap left, walls up/left, tie UP/LEFT, dead-end, enclosed, reverseOk on/off, wrap right, open down
    vPos = '{160, 330, 330, 330, 330, 330, 330, 127, 330};
    vDir = '{1, 3, 0, 0, 0, 0, 0, 3, 2};
    vTgt = '{191, 228, 297, 165, 165, 650, 650, 96, 650};
    vUp  = '{0, 32'h400, 0, 32'h400, 32'h400, 0, 0, 0, 0};
    vMid = '{0, 32'h200, 0, 32'hA00, 32'hA00, 0, 0, 0, 0};
    vDn  = '{0, 0, 0, 0, 32'h400, 0, 0, 0, 0};
    vRev = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    ePos = '{191, 362, 298, 362, 330, 362, 329, 96, 362};
    eDir = '{1, 2, 0, 2, 0, 2, 1, 3, 2};
    for (int i = 0; i < 9; i++) begin
      selCurPos = vPos[i];
      selCurDir = dir_t'(vDir[i]);
      selTarget = vTgt[i];
      selRowUp  = vUp[i];
      selRowMid = vMid[i];
      selRowDn  = vDn[i];
      selRevOk  = vRev[i];
      #1;
      testsRun++;
      if (selNextPos !== ePos[i] || selNextDir !== dir_t'(eDir[i])) begin
        testsFailed++;
        $display("FAIL step_select_%0d: got pos=%0d dir=%0d want %0d/%0d", i, selNextPos, selNextDir, ePos[i], eDir[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    start_tick = 1'b0;
    dead_i = '0;
    target_i = '0;
    selCurPos = '0;
    selCurDir = UP;
    selTarget = '0;
    selRowUp = '0;
    selRowMid = '0;
    selRowDn = '0;
    selRevOk = 1'b0;
    for (int i = 0; i < 32; i++) maze[i] = 32'h0;
    do_reset();
    test_reset();
`ifdef GHOST_SCATTER_EN
    test_scatter();
`else
    test_first_move();
    test_back_to_back();
    test_overrun();
    test_y0_wrap();
    test_dead();
`endif
    test_step_select();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
